// File: rtl/dcache_sa2.sv
// rtl/dcache_sa2.sv - 2-way set-associative write-back write-allocate data cache
//
// Ports:
//   CLK, nRST                 clock (rising edge), asynchronous active-low reset
//   halt                      datapath halt; flushes dirty lines then writes the hit count
//   dmemREN/dmemWEN           datapath read/write request, held until dhit
//   dmemaddr/dmemstore        datapath word address / write data
//   dhit/dmemload             request complete / read data
//   flushed                   flush and hit-count write complete
//   dREN/dWEN/daddr/dstore    memory read/write beat
//   dload/dwait               memory read data / memory busy
module dcache_sa2 #(
    parameter int          SETS     = 8,
    parameter int          WORDS    = 2,
    parameter logic [31:0] HIT_ADDR = 32'h3100
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        halt,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic [31:0] dload,
    input  logic        dwait
);
    localparam int B  = $clog2(WORDS);
    localparam int I  = $clog2(SETS);
    localparam int TW = 32 - B - I - 2;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WB    = 3'd1;
    localparam logic [2:0] S_FILL  = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_CNT   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [B-1:0] K_LAST = B'(WORDS - 1);

    // Line state, indexed [way][set]
    logic [SETS-1:0] r_valid [2];
    logic [SETS-1:0] r_dirty [2];
    logic [SETS-1:0] r_lru;                 // way to evict next, per set
    logic [TW-1:0]   r_tag  [2][SETS];
    logic [31:0]     r_data [2][SETS][WORDS];

    logic [2:0]    r_state;
    logic [B-1:0]  r_k;                     // beat counter for WB/FILL/FLUSH
    logic          r_vway;                  // victim way of the pending miss
    logic [I-1:0]  r_ridx;
    logic [TW-1:0] r_rtag;
    logic          r_fway;                  // flush walk position
    logic [I-1:0]  r_fset;
    logic [31:0]   r_hits;
    logic          r_miss_pending;

    logic [TW-1:0] w_tag;
    logic [I-1:0]  w_idx;
    logic [B-1:0]  w_off;
    logic          w_req;
    logic          w_hit0;
    logic          w_hit1;
    logic          w_hway;
    logic          w_idle_hit;
    logic          w_vict;
    logic          w_vict_dirty;
    logic          w_fdirty;
    logic          w_k_last;
    logic          w_unused;

    assign w_tag    = dmemaddr[31:B+I+2];
    assign w_idx    = dmemaddr[B+I+1:B+2];
    assign w_off    = dmemaddr[B+1:2];
    assign w_unused = &{1'b0, dmemaddr[1:0]};
    assign w_req    = dmemREN | dmemWEN;

    assign w_hit0 = r_valid[0][w_idx] && (r_tag[0][w_idx] == w_tag);
    assign w_hit1 = r_valid[1][w_idx] && (r_tag[1][w_idx] == w_tag);
    assign w_hway = ~w_hit0;
    assign w_idle_hit = (r_state == S_IDLE) && !halt && w_req && (w_hit0 || w_hit1);

    // Fill empty ways first (way 0 before way 1), otherwise evict the LRU way
    assign w_vict = !r_valid[0][w_idx] ? 1'b0 :
                    !r_valid[1][w_idx] ? 1'b1 : r_lru[w_idx];
    assign w_vict_dirty = r_valid[w_vict][w_idx] && r_dirty[w_vict][w_idx];

    assign w_fdirty = r_valid[r_fway][r_fset] && r_dirty[r_fway][r_fset];
    assign w_k_last = (r_k == K_LAST);

    always_comb begin
        dhit     = 1'b0;
        dmemload = 32'h0;
        flushed  = 1'b0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        daddr    = 32'h0;
        dstore   = 32'h0;
        case (r_state)
            S_IDLE: begin
                dhit = w_idle_hit;
                if (w_idle_hit && !dmemWEN)
                    dmemload = r_data[w_hway][w_idx][w_off];
            end
            S_WB: begin
                dWEN   = 1'b1;
                daddr  = {r_tag[r_vway][r_ridx], r_ridx, r_k, 2'b00};
                dstore = r_data[r_vway][r_ridx][r_k];
            end
            S_FILL: begin
                dREN  = 1'b1;
                daddr = {r_rtag, r_ridx, r_k, 2'b00};
            end
            S_FLUSH: begin
                if (w_fdirty) begin
                    dWEN   = 1'b1;
                    daddr  = {r_tag[r_fway][r_fset], r_fset, r_k, 2'b00};
                    dstore = r_data[r_fway][r_fset][r_k];
                end
            end
            S_CNT: begin
                dWEN   = 1'b1;
                daddr  = HIT_ADDR;
                dstore = r_hits;
            end
            S_DONE:  flushed = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state        <= S_IDLE;
            r_valid[0]     <= '0;
            r_valid[1]     <= '0;
            r_dirty[0]     <= '0;
            r_dirty[1]     <= '0;
            r_lru          <= '0;
            r_k            <= '0;
            r_vway         <= 1'b0;
            r_ridx         <= '0;
            r_rtag         <= '0;
            r_fway         <= 1'b0;
            r_fset         <= '0;
            r_hits         <= 32'h0;
            r_miss_pending <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (halt) begin
                        r_state <= S_FLUSH;
                        r_fway  <= 1'b0;
                        r_fset  <= '0;
                        r_k     <= '0;
                    end else if (w_idle_hit) begin
                        if (dmemWEN)
                            r_dirty[w_hway][w_idx] <= 1'b1;
                        r_lru[w_idx]   <= ~w_hway;
                        r_miss_pending <= 1'b0;
                        // The completing hit of a missed request is not counted
                        if (!r_miss_pending)
                            r_hits <= r_hits + 32'd1;
                    end else if (w_req) begin
                        r_vway         <= w_vict;
                        r_ridx         <= w_idx;
                        r_rtag         <= w_tag;
                        r_k            <= '0;
                        r_miss_pending <= 1'b1;
                        r_state        <= w_vict_dirty ? S_WB : S_FILL;
                    end
                end
                S_WB: begin
                    if (!dwait) begin
                        r_k <= r_k + 1'b1;
                        if (w_k_last)
                            r_state <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (!dwait) begin
                        r_k <= r_k + 1'b1;
                        if (w_k_last) begin
                            r_valid[r_vway][r_ridx] <= 1'b1;
                            r_dirty[r_vway][r_ridx] <= 1'b0;
                            r_state                 <= S_IDLE;
                        end
                    end
                end
                S_FLUSH: begin
                    // Clean or invalid lines take one cycle; dirty lines move on
                    // after their last write beat
                    if (!w_fdirty || (!dwait && w_k_last)) begin
                        r_k <= '0;
                        if (w_fdirty)
                            r_dirty[r_fway][r_fset] <= 1'b0;
                        r_fset <= r_fset + 1'b1;
                        if (r_fset == I'(SETS - 1)) begin
                            if (r_fway)
                                r_state <= S_CNT;
                            r_fway <= 1'b1;
                        end
                    end else if (!dwait) begin
                        r_k <= r_k + 1'b1;
                    end
                end
                S_CNT: begin
                    if (!dwait)
                        r_state <= S_DONE;
                end
                S_DONE:  r_state <= S_DONE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Data and tag arrays carry no reset; a line is meaningless until valid
    always_ff @(posedge CLK) begin
        if (w_idle_hit && dmemWEN)
            r_data[w_hway][w_idx][w_off] <= dmemstore;
        if (r_state == S_FILL && !dwait) begin
            r_data[r_vway][r_ridx][r_k] <= dload;
            if (w_k_last)
                r_tag[r_vway][r_ridx] <= r_rtag;
        end
    end
endmodule

// File: tb/tb_dcache_sa2.sv
// tb/tb_dcache_sa2.sv - self-checking bench for dcache_sa2
module tb_dcache_sa2;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return 32'hC0DE0000 ^ a;
    endfunction

    // Instance A: SETS=8, WORDS=2
    logic        a_rst_n, a_halt, a_ren, a_wen;
    logic [31:0] a_addr, a_store, a_load, a_daddr, a_dstore, a_dload;
    logic        a_dhit, a_flushed, a_dren, a_dwen, a_dwait;
    int          a_wait_n;
    int          a_wcnt;

    assign a_dwait = (a_wcnt < a_wait_n);
    assign a_dload = (a_daddr == 32'h100) ? 32'hA5A5A5A5 : init_val(a_daddr);

    always @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n)                 a_wcnt <= 0;
        else if (a_dren | a_dwen)     a_wcnt <= a_dwait ? a_wcnt + 1 : 0;
        else                          a_wcnt <= 0;
    end

    dcache_sa2 #(.SETS(8), .WORDS(2), .HIT_ADDR(32'h3100)) u_a (
        .CLK(clk), .nRST(a_rst_n), .halt(a_halt), .dmemREN(a_ren), .dmemWEN(a_wen),
        .dmemaddr(a_addr), .dmemstore(a_store), .dhit(a_dhit), .dmemload(a_load),
        .flushed(a_flushed), .dREN(a_dren), .dWEN(a_dwen), .daddr(a_daddr),
        .dstore(a_dstore), .dload(a_dload), .dwait(a_dwait)
    );

    // Instance B: SETS=16, WORDS=4, memory never busy
    logic        b_rst_n, b_halt, b_ren, b_wen;
    logic [31:0] b_addr, b_store, b_load, b_daddr, b_dstore, b_dload;
    logic        b_dhit, b_flushed, b_dren, b_dwen, b_dwait;

    assign b_dwait = 1'b0;
    assign b_dload = init_val(b_daddr);

    dcache_sa2 #(.SETS(16), .WORDS(4), .HIT_ADDR(32'h3100)) u_b (
        .CLK(clk), .nRST(b_rst_n), .halt(b_halt), .dmemREN(b_ren), .dmemWEN(b_wen),
        .dmemaddr(b_addr), .dmemstore(b_store), .dhit(b_dhit), .dmemload(b_load),
        .flushed(b_flushed), .dREN(b_dren), .dWEN(b_dwen), .daddr(b_daddr),
        .dstore(b_dstore), .dload(b_dload), .dwait(b_dwait)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_load;
        logic        fill;
        logic        wb;
        logic [31:0] wb_base;
        logic [31:0] wb_d0;
        logic [31:0] wb_d1;
    } vec_t;

    beat_t       exp_beats[$];
    logic [31:0] exp_loads[$];
    logic [31:0] b_exp[$];
    vec_t        vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_beat(input logic we, input logic [31:0] addr, input logic [31:0] data);
        beat_t b;
        b.we = we; b.addr = addr; b.data = data;
        exp_beats.push_back(b);
    endtask

    // Called at a negedge: compare a completing memory beat against the scoreboard
    task automatic bus_step();
        beat_t b;
        if (a_rst_n && (a_dren | a_dwen) && !a_dwait) begin
            if (exp_beats.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_beat: got we=%0b addr=%h expected no beat", a_dwen, a_daddr);
            end else begin
                b = exp_beats.pop_front();
                check("beat_we", {31'b0, a_dwen}, {31'b0, b.we});
                check("beat_ren", {31'b0, a_dren}, {31'b0, ~b.we});
                check("beat_addr", a_daddr, b.addr);
                if (b.we) check("beat_data", a_dstore, b.data);
            end
        end
    endtask

    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_load, input int exp_n);
        int  n;
        logic got;
        @(posedge clk); #1;
        a_wen = we; a_ren = ~we; a_addr = addr; a_store = wdata;
        if (!we) exp_loads.push_back(exp_load);
        n = 0; got = 1'b0;
        while (n < 200 && !got) begin
            @(negedge clk);
            bus_step();
            if (a_dhit) got = 1'b1;
            else n++;
        end
        if (!got) begin
            n_tests++; n_fail++;
            $display("FAIL dhit_timeout: got no dhit for %h expected dhit", addr);
        end else begin
            check("latency", n, exp_n);
            if (!we) check("load", a_load, exp_loads.pop_front());
        end
        @(posedge clk); #1;
        a_ren = 1'b0; a_wen = 1'b0;
        check("beats_left", exp_beats.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic got;
        vecs[0] = '{1'b0, 32'h100, 32'h0,        32'hA5A5A5A5,     1'b1, 1'b0, 32'h0,   32'h0,        32'h0};
        vecs[1] = '{1'b1, 32'h104, 32'hDEADBEEF, 32'h0,            1'b0, 1'b0, 32'h0,   32'h0,        32'h0};
        vecs[2] = '{1'b0, 32'h104, 32'h0,        32'hDEADBEEF,     1'b0, 1'b0, 32'h0,   32'h0,        32'h0};
        vecs[3] = '{1'b0, 32'h200, 32'h0,        init_val(32'h200), 1'b1, 1'b0, 32'h0,  32'h0,        32'h0};
        vecs[4] = '{1'b0, 32'h100, 32'h0,        32'hA5A5A5A5,     1'b0, 1'b0, 32'h0,   32'h0,        32'h0};
        vecs[5] = '{1'b0, 32'h300, 32'h0,        init_val(32'h300), 1'b1, 1'b0, 32'h0,  32'h0,        32'h0};
        vecs[6] = '{1'b0, 32'h400, 32'h0,        init_val(32'h400), 1'b1, 1'b1, 32'h100, 32'hA5A5A5A5, 32'hDEADBEEF};
        vecs[7] = '{1'b1, 32'h404, 32'h22222222, 32'h0,            1'b0, 1'b0, 32'h0,   32'h0,        32'h0};
        vecs[8] = '{1'b1, 32'h304, 32'h33333333, 32'h0,            1'b0, 1'b0, 32'h0,   32'h0,        32'h0};

        a_rst_n = 1'b0; a_halt = 1'b0; a_ren = 1'b0; a_wen = 1'b0;
        a_addr = 32'h0; a_store = 32'h0; a_wait_n = 0;
        b_rst_n = 1'b0; b_halt = 1'b0; b_ren = 1'b0; b_wen = 1'b0;
        b_addr = 32'h0; b_store = 32'h0;
        #1;
        check("rst_dhit",    {31'b0, a_dhit},    32'h0);
        check("rst_flushed", {31'b0, a_flushed}, 32'h0);
        check("rst_dren",    {31'b0, a_dren},    32'h0);
        check("rst_dwen",    {31'b0, a_dwen},    32'h0);
        check("rst_daddr",   a_daddr,            32'h0);
        check("rst_dstore",  a_dstore,           32'h0);
        check("rst_load",    a_load,             32'h0);
        check("rst_b_dren",  {31'b0, b_dren},    32'h0);
        @(posedge clk); @(posedge clk); #1;
        a_rst_n = 1'b1; b_rst_n = 1'b1;

        // Cold miss, write/read hits and LRU replacement
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].wb) begin
                push_beat(1'b1, vecs[i].wb_base,         vecs[i].wb_d0);
                push_beat(1'b1, vecs[i].wb_base + 32'h4, vecs[i].wb_d1);
            end
            if (vecs[i].fill) begin
                push_beat(1'b0, vecs[i].addr & ~32'h7,          32'h0);
                push_beat(1'b0, (vecs[i].addr & ~32'h7) + 32'h4, 32'h0);
            end
            access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_load,
                   vecs[i].fill ? (vecs[i].wb ? 5 : 3) : 0);
        end

        // Flush of two dirty lines in way/set order, then hit count 5
        push_beat(1'b1, 32'h400, init_val(32'h400));
        push_beat(1'b1, 32'h404, 32'h22222222);
        push_beat(1'b1, 32'h300, init_val(32'h300));
        push_beat(1'b1, 32'h304, 32'h33333333);
        push_beat(1'b1, 32'h3100, 32'd5);
        @(posedge clk); #1;
        a_halt = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 500 && !got; c++) begin
            @(negedge clk);
            bus_step();
            if (a_flushed) got = 1'b1;
        end
        check("flushed_reached", {31'b0, got}, 32'h1);
        check("flush_beats_left", exp_beats.size(), 0);
        @(posedge clk); #1;
        a_ren = 1'b1; a_addr = 32'h400;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("done_flushed", {31'b0, a_flushed}, 32'h1);
            check("done_bus", {30'b0, a_dren, a_dwen}, 32'h0);
            check("done_daddr", a_daddr, 32'h0);
            check("done_dhit", {31'b0, a_dhit}, 32'h0);
        end

        // Reset in the middle of a slow fill, between beats
        @(posedge clk); #1;
        a_ren = 1'b0; a_halt = 1'b0; a_rst_n = 1'b0;
        @(posedge clk); #1;
        a_rst_n = 1'b1; a_wait_n = 3;
        push_beat(1'b0, 32'h500, 32'h0);
        a_ren = 1'b1; a_addr = 32'h500;
        got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            bus_step();
            if (exp_beats.size() == 0) got = 1'b1;
        end
        check("first_beat_done", {31'b0, got}, 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        check("second_beat_busy", {30'b0, a_dren, a_dwait}, 32'h3);
        #1 a_rst_n = 1'b0;
        #1;
        check("midrst_dren",  {31'b0, a_dren}, 32'h0);
        check("midrst_daddr", a_daddr,         32'h0);
        check("midrst_dhit",  {31'b0, a_dhit}, 32'h0);
        a_ren = 1'b0;
        @(posedge clk); #1;
        a_rst_n = 1'b1; a_wait_n = 0;
        push_beat(1'b0, 32'h500, 32'h0);
        push_beat(1'b0, 32'h504, 32'h0);
        access(1'b0, 32'h500, 32'h0, init_val(32'h500), 3);

        // SETS=16, WORDS=4 fill order
        b_exp.push_back(32'h40); b_exp.push_back(32'h44);
        b_exp.push_back(32'h48); b_exp.push_back(32'h4C);
        @(posedge clk); #1;
        b_ren = 1'b1; b_addr = 32'h48;
        n = 0; got = 1'b0;
        while (n < 50 && !got) begin
            @(negedge clk);
            if (b_dren | b_dwen) begin
                check("b_dwen", {31'b0, b_dwen}, 32'h0);
                if (b_exp.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL b_unexpected_beat: got addr %h expected no beat", b_daddr);
                end else
                    check("b_beat_addr", b_daddr, b_exp.pop_front());
            end
            if (b_dhit) got = 1'b1;
            else n++;
        end
        check("b_dhit", {31'b0, got}, 32'h1);
        check("b_latency", n, 5);
        check("b_load", b_load, init_val(32'h48));
        check("b_beats_left", b_exp.size(), 0);
        @(posedge clk); #1;
        b_ren = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dcache_sa2.md
# dcache_sa2

Parametrised 2-way set-associative, write-back, write-allocate data cache between the datapath (dmem* side) and the memory controller (d* side). It is the next generation of the team's data cache. It generalises set count and block size, and tracks LRU per set rather than with one global bit. On halt it flushes every dirty block of any size, then writes the hit count. It replaces the fixed 8-set, 2-word cache.

## Interface
- SETS, 8, number of sets; power of 2, ≥2
- WORDS, 2, 32-bit words per block; power of 2, ≥2
- HIT_ADDR, 32'h3100, address the hit counter is written to at the end of a flush
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- halt  in  1  datapath halt request
- dmemREN / dmemWEN  in  1 each  datapath read / write request, held until dhit
- dmemaddr  in  32  word address; [1:0] ignored
- dmemstore  in  32  write data
- dhit  out  1  request complete this cycle
- dmemload  out  32  read data, valid with dhit
- flushed  out  1  flush and counter write complete
- dREN / dWEN  out  1 each  memory read / write
- daddr / dstore  out  32  memory address / write data
- dload  in  32  memory read data, valid when dwait=0
- dwait  in  1  memory busy; a beat completes in the cycle dREN|dWEN=1 and dwait=0

## Operation
- Address split: B=log2(WORDS), I=log2(SETS). blkoff=[B+1:2], idx=[B+I+1:B+2], tag=[31:B+I+2].
- Each line holds valid, dirty, tag and WORDS words. Each set holds one LRU bit naming the way to evict next.
- States: IDLE, WB, FILL, FLUSH, CNT, DONE.
- IDLE, in priority order:
  - halt=1 → FLUSH.
  - Request hits a way → dhit=1 the same cycle. A read drives dmemload. A write updates the word and sets dirty. LRU points to the other way.
  - Request misses → choose the victim: the first invalid way (way 0 first), else the LRU way. A valid, dirty victim → WB; otherwise → FILL.
- If dmemWEN and dmemREN are both high, the request is a write.
- WB: WORDS write beats, k=0..WORDS-1.
  - daddr={victim tag, idx, k, 2'b00}, dstore=victim word k.
  - k advances on dwait=0. After the last beat → FILL.
- FILL: WORDS read beats, k=0..WORDS-1.
  - daddr={req tag, idx, k, 2'b00}. On each dwait=0, dload is written to word k.
  - After the last beat: line valid=1, dirty=0, tag=req tag; → IDLE, where the request hits on the next cycle.
- Hit counter: 32-bit, wraps. It increments on every dhit whose request did not take a miss. A miss_pending flag is set when leaving IDLE on a miss and cleared on the next dhit.
- Halt during WB/FILL is ignored until the state returns to IDLE.
- FLUSH walks way 0 sets 0..SETS-1, then way 1 sets 0..SETS-1.
  - A line that is not both valid and dirty costs 1 cycle.
  - A valid, dirty line is written as WORDS beats, same addressing as WB, then its dirty bit is cleared.
  - After the last line → CNT.
- CNT: dWEN=1, daddr=HIT_ADDR, dstore=counter. On dwait=0 → DONE.
- DONE: flushed=1 and all bus outputs 0. Held until reset; further requests are ignored.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE; all valid, dirty and LRU bits 0; counter 0; miss_pending 0.
- Reset asserted mid-operation abandons any beat in progress and returns the cache to empty on the next cycle after release.
- Hit: combinational, 0 extra cycles. dhit is high for one cycle per completed request.
- The datapath drops or changes its request after dhit. A request still held on the next cycle is a new access.
- Clean miss: WORDS beats + 1 IDLE cycle. Dirty miss: 2·WORDS beats + 1 cycle.
- Each beat lasts ≥1 cycle. dREN/dWEN, daddr and dstore are stable while dwait=1.
- Beat counter k wraps to 0 after WORDS-1. The FLUSH set index covers the full range 0..SETS-1 of each way.

## Test plan
- Cold read miss (SETS=8, WORDS=2), read 0x100 with mem[0x100]=0xA5A5A5A5 → dREN beats at 0x100 and 0x104, then dhit with dmemload=0xA5A5A5A5; counter stays 0.
- Write 0x104←0xDEADBEEF after the miss above, then read 0x104 → both dhit in their first cycle with no bus traffic; the read returns 0xDEADBEEF; counter=2.
- LRU replacement:
  - Access 0x100 (dirty) and 0x200, re-read 0x100, then read 0x300.
  - The 0x300 access evicts 0x200 with no WB.
  - A following read of 0x400 evicts dirty 0x100: dWEN at 0x100 and 0x104, then dREN at 0x400 and 0x404.
- SETS=16, WORDS=4, read 0x48 → four dREN beats at 0x40, 0x44, 0x48, 0x4C; dmemload=mem[0x48].
- Halt with 2 dirty lines and counter=5 → exactly 4 write beats in way/set order, then one dWEN at 0x3100 with dstore=5; flushed=1 and held.
- dwait held high 3 cycles per beat during a fill, with nRST pulsed between beats → outputs 0 immediately on reset; the next read of the same address misses again.
